mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the shared test-bench memory. It accepts read/write requests from the instruction-fetch port (port 0) and the data port (port 1) and picks one. It drives the memory's single req_rdwr/data_ready handshake and returns read data plus a one-cycle ack, or an error on timeout, to the winner. It sits between the CPU's fetch/load-store units and the memory model.

---
 rtl/mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch (port 0) and data (port 1) requests onto the shared memory handshake.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin; the default build gives port 1 fixed priority.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic              sz_0,
  input  logic              sz_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [7:0]        wdata8_0,
  input  logic [7:0]        wdata8_1,
  input  logic [15:0]       wdata16_0,
  input  logic [15:0]       wdata16_1,
  output logic              ack_0,
  output logic              ack_1,
  output logic              err_0,
  output logic              err_1,
  output logic [7:0]        rdata_8,
  output logic [15:0]       rdata_16,
  output logic              mem_req_rdwr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_sz,
  output logic              mem_we_8,
  output logic              mem_we_16,
  output logic [7:0]        mem_wdata_8,
  output logic [15:0]       mem_wdata_16,
  input  logic [7:0]        mem_rdata_8,
  input  logic [15:0]       mem_rdata_16,
  input  logic              mem_data_ready
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned D8_W     = 8;
  localparam int unsigned D16_W    = 16;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              sz;
    logic              we;
    logic [D8_W-1:0]   wdata8;
    logic [D16_W-1:0]  wdata16;
  } cmd_t;

  state_t             r_state;
  state_t             w_state_nxt;

  cmd_t               w_cmd_0;
  cmd_t               w_cmd_1;
  cmd_t               w_cmd_sel;
  logic               w_any_req;
  logic               w_grant_sel;
  logic               w_busy_done;
  logic               w_busy_tmo;

  logic               r_winner;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_ack;
  logic [1:0]         r_err;
  logic [D8_W-1:0]    r_rdata_8;
  logic [D16_W-1:0]   r_rdata_16;
  logic               r_req_rdwr;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_sz;
  logic               r_we_8;
  logic               r_we_16;
  logic [D8_W-1:0]    r_wdata_8;
  logic [D16_W-1:0]   r_wdata_16;

  logic               w_winner_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         w_ack_nxt;
  logic [1:0]         w_err_nxt;
  logic [D8_W-1:0]    w_rdata_8_nxt;
  logic [D16_W-1:0]   w_rdata_16_nxt;
  logic               w_req_rdwr_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic               w_sz_nxt;
  logic               w_we_8_nxt;
  logic               w_we_16_nxt;
  logic [D8_W-1:0]    w_wdata_8_nxt;
  logic [D16_W-1:0]   w_wdata_16_nxt;

  // Per-port command bundles and the grant mux
  assign w_cmd_0 = '{addr: addr_0, sz: sz_0, we: we_0, wdata8: wdata8_0, wdata16: wdata16_0};
  assign w_cmd_1 = '{addr: addr_1, sz: sz_1, we: we_1, wdata8: wdata8_1, wdata16: wdata16_1};
  assign w_any_req = req_0 | req_1;
  assign w_cmd_sel = w_grant_sel ? w_cmd_1 : w_cmd_0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On contention grant the port that lost last time; a lone requester always wins
  always_comb begin
    w_grant_sel = req_1;
    if (req_0 && req_1) begin
      w_grant_sel = ~r_last_grant;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_last_grant <= w_grant_sel;
    end
  end
`else
  // Data port always beats fetch port
  always_comb begin
    w_grant_sel = req_1;
  end
`endif

  // data_ready takes precedence over a coincident timeout
  assign w_busy_done = (r_state == S_BUSY) && mem_data_ready;
  assign w_busy_tmo  = (r_state == S_BUSY) && !mem_data_ready && (r_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_busy_done || w_busy_tmo) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for every registered output and datapath register
  always_comb begin
    w_winner_nxt    = r_winner;
    w_cnt_nxt       = r_cnt;
    w_ack_nxt       = 2'b00;
    w_err_nxt       = 2'b00;
    w_rdata_8_nxt   = r_rdata_8;
    w_rdata_16_nxt  = r_rdata_16;
    w_req_rdwr_nxt  = r_req_rdwr;
    w_addr_nxt      = r_addr;
    w_sz_nxt        = r_sz;
    w_we_8_nxt      = r_we_8;
    w_we_16_nxt     = r_we_16;
    w_wdata_8_nxt   = r_wdata_8;
    w_wdata_16_nxt  = r_wdata_16;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_winner_nxt   = w_grant_sel;
          w_cnt_nxt      = '0;
          w_req_rdwr_nxt = 1'b1;
          w_addr_nxt     = w_cmd_sel.addr;
          w_sz_nxt       = w_cmd_sel.sz;
          w_we_8_nxt     = w_cmd_sel.we & ~w_cmd_sel.sz;
          w_we_16_nxt    = w_cmd_sel.we &  w_cmd_sel.sz;
          w_wdata_8_nxt  = w_cmd_sel.wdata8;
          w_wdata_16_nxt = w_cmd_sel.wdata16;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_busy_done) begin
          w_rdata_8_nxt       = mem_rdata_8;
          w_rdata_16_nxt      = mem_rdata_16;
          w_ack_nxt[r_winner] = 1'b1;
          w_req_rdwr_nxt      = 1'b0;
          w_we_8_nxt          = 1'b0;
          w_we_16_nxt         = 1'b0;
        end else if (w_busy_tmo) begin
          w_rdata_8_nxt       = '0;
          w_rdata_16_nxt      = '0;
          w_ack_nxt[r_winner] = 1'b1;
          w_err_nxt[r_winner] = 1'b1;
          w_req_rdwr_nxt      = 1'b0;
          w_we_8_nxt          = 1'b0;
          w_we_16_nxt         = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_winner   <= 1'b0;
      r_cnt      <= '0;
      r_ack      <= 2'b00;
      r_err      <= 2'b00;
      r_rdata_8  <= '0;
      r_rdata_16 <= '0;
      r_req_rdwr <= 1'b0;
      r_addr     <= '0;
      r_sz       <= 1'b0;
      r_we_8     <= 1'b0;
      r_we_16    <= 1'b0;
      r_wdata_8  <= '0;
      r_wdata_16 <= '0;
    end else begin
      r_winner   <= w_winner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_rdata_8  <= w_rdata_8_nxt;
      r_rdata_16 <= w_rdata_16_nxt;
      r_req_rdwr <= w_req_rdwr_nxt;
      r_addr     <= w_addr_nxt;
      r_sz       <= w_sz_nxt;
      r_we_8     <= w_we_8_nxt;
      r_we_16    <= w_we_16_nxt;
      r_wdata_8  <= w_wdata_8_nxt;
      r_wdata_16 <= w_wdata_16_nxt;
    end
  end

  assign ack_0        = r_ack[0];
  assign ack_1        = r_ack[1];
  assign err_0        = r_err[0];
  assign err_1        = r_err[1];
  assign rdata_8      = r_rdata_8;
  assign rdata_16     = r_rdata_16;
  assign mem_req_rdwr = r_req_rdwr;
  assign mem_addr     = r_addr;
  assign mem_sz       = r_sz;
  assign mem_we_8     = r_we_8;
  assign mem_we_16    = r_we_16;
  assign mem_wdata_8  = r_wdata_8;
  assign mem_wdata_16 = r_wdata_16;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level timeline model predicts grant order, ack cycle and data.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 16;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic reset;
  logic req_0, req_1, sz_0, sz_1, we_0, we_1;
  logic [15:0] addr_0, addr_1, wdata16_0, wdata16_1;
  logic [7:0]  wdata8_0, wdata8_1;
  logic ack_0, ack_1, err_0, err_1;
  logic [7:0]  rdata_8;
  logic [15:0] rdata_16;
  logic mem_req_rdwr, mem_sz, mem_we_8, mem_we_16;
  logic [15:0] mem_addr, mem_wdata_16, mem_rdata_16;
  logic [7:0]  mem_wdata_8, mem_rdata_8;
  logic mem_data_ready;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .addr_0(addr_0), .addr_1(addr_1),
    .sz_0(sz_0), .sz_1(sz_1), .we_0(we_0), .we_1(we_1),
    .wdata8_0(wdata8_0), .wdata8_1(wdata8_1), .wdata16_0(wdata16_0), .wdata16_1(wdata16_1),
    .ack_0(ack_0), .ack_1(ack_1), .err_0(err_0), .err_1(err_1),
    .rdata_8(rdata_8), .rdata_16(rdata_16),
    .mem_req_rdwr(mem_req_rdwr), .mem_addr(mem_addr), .mem_sz(mem_sz),
    .mem_we_8(mem_we_8), .mem_we_16(mem_we_16),
    .mem_wdata_8(mem_wdata_8), .mem_wdata_16(mem_wdata_16),
    .mem_rdata_8(mem_rdata_8), .mem_rdata_16(mem_rdata_16), .mem_data_ready(mem_data_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [7:0] init_byte(input int a);
    if (a == 16'h0010) return 8'hA5;
    return 8'(a * 37 + (a >> 8) + 5);
  endfunction

  // Memory model: data_ready mem_lat cycles after req_rdwr rises; writes land with data_ready
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [15:0] mem_a1;
  int  mem_lat;
  bit  mem_nodr;
  int  m_cnt;
  bit  m_init = 1'b0;

  assign mem_a1       = mem_addr + 16'd1;
  assign mem_rdata_8  = mem[mem_addr];
  assign mem_rdata_16 = {mem[mem_a1], mem[mem_addr]};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_data_ready <= 1'b0;
      m_cnt <= 0;
      if (!m_init) begin
        for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
        m_init <= 1'b1;
      end
    end else if (mem_req_rdwr && !mem_data_ready && !mem_nodr) begin
      if (m_cnt == mem_lat - 1) begin
        mem_data_ready <= 1'b1;
        m_cnt <= 0;
        if (mem_we_8) mem[mem_addr] <= mem_wdata_8;
        if (mem_we_16) begin
          mem[mem_addr] <= mem_wdata_16[7:0];
          mem[mem_a1]   <= mem_wdata_16[15:8];
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      mem_data_ready <= 1'b0;
      m_cnt <= 0;
    end
  end

  typedef struct {
    int          port;
    bit          err;
    bit          we;
    bit          sz;
    logic [15:0] addr;
    logic [7:0]  w8;
    logic [15:0] w16;
    logic [7:0]  rd8;
    logic [15:0] rd16;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    bit          sz;
    bit          we;
    logic [7:0]  w8;
    logic [15:0] w16;
  } cmd_t;

  exp_t exp_q[$];
  cmd_t cmd[2];
`ifdef MEM_ARB_ROUND_ROBIN_EN
  int last_g = 1;
`endif

  // Monitor: checks the in-flight command every cycle and each ack against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (reset && mon_en) begin
      if (mem_req_rdwr) begin
        if (exp_q.size() == 0) fail_now("cmd_without_txn");
        else begin
          e = exp_q[0];
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_sz_we", 32'({mem_sz, mem_we_16, mem_we_8}),
              32'({e.sz, e.we & e.sz, e.we & ~e.sz}));
          if (e.we) chk("mem_wdata", e.sz ? 32'(mem_wdata_16) : 32'(mem_wdata_8),
                        e.sz ? 32'(e.w16) : 32'(e.w8));
        end
      end else begin
        chk("mem_we_idle", 32'({mem_we_16, mem_we_8}), 32'd0);
      end
      if (ack_0 || ack_1 || err_0 || err_1) begin
        if (exp_q.size() == 0) fail_now("unexpected_ack");
        else begin
          e = exp_q.pop_front();
          chk("ack_port", 32'({ack_1, ack_0}), (e.port == 1) ? 32'd2 : 32'd1);
          chk("err", 32'({err_1, err_0}), e.err ? ((e.port == 1) ? 32'd2 : 32'd1) : 32'd0);
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          chk("req_rdwr_low_in_ack", 32'(mem_req_rdwr), 32'd0);
          if (e.err) chk("rdata_timeout", 32'({rdata_16, rdata_8}), 32'd0);
          else if (!e.we) begin
            if (e.sz) chk("rdata_16", 32'(rdata_16), 32'(e.rd16));
            else      chk("rdata_8", 32'(rdata_8), 32'(e.rd8));
          end
        end
      end
    end
  end

  task automatic set_cmd(input int p, input logic [15:0] a, input bit sz, input bit we,
                         input logic [7:0] w8, input logic [15:0] w16);
    cmd[p].addr = a; cmd[p].sz = sz; cmd[p].we = we; cmd[p].w8 = w8; cmd[p].w16 = w16;
  endtask

  task automatic rand_cmd(input int p);
    set_cmd(p, 16'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), 16'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_g = 1;
`endif
    @(posedge clk); #1;
  endtask

  // Port p issues n[p] transactions, raising req d[p] cycles into the round; starts at the current cycle
  task automatic run_round(input int n0, input int n1, input int d0, input int d1,
                           input int lat, input bit nodr);
    int nn[2]; int rem[2]; int got[2];
    int start, t, g, c, budget;
    bit p0, p1, tmo;
    exp_t e;
    logic [15:0] a, a1;
    nn[0] = n0; nn[1] = n1;
    mem_lat = lat; mem_nodr = nodr;
    addr_0 = cmd[0].addr; sz_0 = cmd[0].sz; we_0 = cmd[0].we; wdata8_0 = cmd[0].w8; wdata16_0 = cmd[0].w16;
    addr_1 = cmd[1].addr; sz_1 = cmd[1].sz; we_1 = cmd[1].we; wdata8_1 = cmd[1].w8; wdata16_1 = cmd[1].w16;
    start = cyc; t = start; rem[0] = n0; rem[1] = n1;
    tmo = nodr || (lat >= TMO);
    while (rem[0] + rem[1] > 0) begin
      p0 = (rem[0] > 0) && (start + d0 <= t);
      p1 = (rem[1] > 0) && (start + d1 <= t);
      if (!p0 && !p1) begin t++; continue; end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      g = (p0 && p1) ? 1 - last_g : (p1 ? 1 : 0);
      last_g = g;
`else
      g = p1 ? 1 : 0;
`endif
      a = cmd[g].addr; a1 = a + 16'd1;
      e.port = g; e.err = tmo; e.we = cmd[g].we; e.sz = cmd[g].sz; e.addr = a;
      e.w8 = cmd[g].w8; e.w16 = cmd[g].w16;
      e.rd8 = ref_mem[a]; e.rd16 = {ref_mem[a1], ref_mem[a]};
      e.cyc = tmo ? t + 1 + TMO : t + 2 + lat;
      if (cmd[g].we && !tmo) begin
        if (cmd[g].sz) begin ref_mem[a] = cmd[g].w16[7:0]; ref_mem[a1] = cmd[g].w16[15:8]; end
        else ref_mem[a] = cmd[g].w8;
      end
      exp_q.push_back(e);
      rem[g]--;
      t = e.cyc + 1;
    end
    got[0] = 0; got[1] = 0; c = 0;
    budget = (n0 + n1) * (TMO + 6) + d0 + d1 + 10;
    while ((got[0] < nn[0] || got[1] < nn[1]) && c < budget) begin
      if (c == d0 && nn[0] > 0) req_0 = 1'b1;
      if (c == d1 && nn[1] > 0) req_1 = 1'b1;
      @(negedge clk);
      if (ack_0) got[0]++;
      if (ack_1) got[1]++;
      @(posedge clk); #1;
      c++;
      if (req_0 && got[0] >= nn[0]) req_0 = 1'b0;
      if (req_1 && got[1] >= nn[1]) req_1 = 1'b0;
    end
    if (got[0] < nn[0] || got[1] < nn[1]) begin
      fail_now("round_no_ack_within_budget");
      exp_q.delete();
      mon_en = 1'b0;
      do_reset();
      mon_en = 1'b1;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    reset = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    addr_0 = '0; addr_1 = '0; sz_0 = 1'b0; sz_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
    wdata8_0 = '0; wdata8_1 = '0; wdata16_0 = '0; wdata16_1 = '0;
    mem_lat = 1; mem_nodr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_err", 32'({ack_1, ack_0, err_1, err_0}), 32'd0);
    chk("rst_rdata", 32'({rdata_16, rdata_8}), 32'd0);
    chk("rst_req_rdwr", 32'(mem_req_rdwr), 32'd0);
    chk("rst_we", 32'({mem_we_16, mem_we_8}), 32'd0);
    chk("rst_addr_sz", 32'({mem_addr, mem_sz}), 32'd0);
    chk("rst_wdata", 32'({mem_wdata_16, mem_wdata_8}), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Single byte read of the preloaded 0xA5
    set_cmd(0, 16'h0010, 1'b0, 1'b0, 8'h00, 16'h0000);
    run_round(1, 0, 0, 0, 1, 1'b0);
    chk("single_read_a5", 32'(rdata_8), 32'h0000_00A5);

    // 16-bit write then read-back on the data port
    set_cmd(1, 16'h0100, 1'b1, 1'b1, 8'h00, 16'hBEEF);
    run_round(0, 1, 0, 0, 1, 1'b0);
    set_cmd(1, 16'h0100, 1'b1, 1'b0, 8'h00, 16'h0000);
    run_round(0, 1, 0, 0, 1, 1'b0);
    chk("readback_beef", 32'(rdata_16), 32'h0000_BEEF);

    // Contention: both ports hold req for three transactions each
    set_cmd(0, 16'h0020, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_cmd(1, 16'h0022, 1'b1, 1'b0, 8'h00, 16'h0000);
    run_round(3, 3, 0, 0, 1, 1'b0);

    // Timeout with memory silent, then the data_ready/timeout boundary either side
    set_cmd(0, 16'h0030, 1'b1, 1'b0, 8'h00, 16'h0000);
    run_round(1, 0, 0, 0, 1, 1'b1);
    chk("req_rdwr_after_timeout", 32'(mem_req_rdwr), 32'd0);
    run_round(1, 0, 0, 0, TMO - 1, 1'b0);
    run_round(1, 0, 0, 0, TMO, 1'b0);

    // Asynchronous reset in the middle of BUSY
    mon_en = 1'b0;
    set_cmd(0, 16'h0012, 1'b0, 1'b0, 8'h00, 16'h0000);
    addr_0 = cmd[0].addr; sz_0 = 1'b0; we_0 = 1'b0;
    mem_lat = 1; mem_nodr = 1'b0;
    req_0 = 1'b1;
    @(posedge clk); #1;
    chk("busy_req_rdwr", 32'(mem_req_rdwr), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async_rst_req_rdwr", 32'(mem_req_rdwr), 32'd0);
    chk("async_rst_no_ack", 32'({ack_1, ack_0, err_1, err_0}), 32'd0);
    req_0 = 1'b0;
    @(negedge clk);
    chk("rst_held_no_ack", 32'({ack_1, ack_0, mem_req_rdwr}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_g = 1;
`endif
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_round(1, 0, 0, 0, 1, 1'b0);

    // Late arrival: port 0 raises while port 1 is BUSY
    set_cmd(0, 16'h0004, 1'b1, 1'b0, 8'h00, 16'h0000);
    set_cmd(1, 16'h0006, 1'b0, 1'b0, 8'h00, 16'h0000);
    run_round(1, 1, 1, 0, 1, 1'b0);

    // Randomised rounds
    for (int r = 0; r < 60; r++) begin
      int n0, n1;
      rand_cmd(0);
      rand_cmd(1);
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      run_round(n0, n1, $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
